// File: rtl/branch_compare_seq_if.sv
// Request/result bundle between the branch comparator and its requester.
// The requester uses the master modport and the comparator uses the slave modport.
interface branch_compare_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic            flags_valid;
    logic            BEQ;
    logic            BNE;
    logic            BLT;
    logic            BGE;
    logic            BLTU;
    logic            BGEU;

    modport master (
        output start, flush, rs1, rs2,
        input  busy, done, flags_valid, BEQ, BNE, BLT, BGE, BLTU, BGEU
    );

    modport slave (
        input  start, flush, rs1, rs2,
        output busy, done, flags_valid, BEQ, BNE, BLT, BGE, BLTU, BGEU
    );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch comparator: compares CHUNK bits per cycle, MSB chunk first.
// When the last chunk has been compared it registers the six branch flags and pulses done.
module branch_compare_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_compare_seq_if.slave  bus
);
    localparam int NCH = XLEN / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            eq_q, eq_d, ltu_q, ltu_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d, fv_q, fv_d;
    logic [5:0]      flags_q, flags_d;     // {BEQ, BNE, BLT, BGE, BLTU, BGEU}
    logic [CHUNK-1:0] a_chunk_s, b_chunk_s;

    // Selects chunk k counting from the MSB end of the operand.
    function automatic logic [CHUNK-1:0] chunk_of(input logic [XLEN-1:0] v, input logic [CW-1:0] k);
        logic [XLEN-1:0] sh;
        sh = v << (int'(k) * CHUNK);
        return sh[XLEN-1 -: CHUNK];
    endfunction

    // Signed less-than only differs from unsigned when the sign bits differ.
    function automatic logic [5:0] make_flags(input logic eq, input logic ltu,
                                              input logic a_msb, input logic b_msb);
        logic lt;
        lt = (a_msb ^ b_msb) ? a_msb : ltu;
        return {eq, ~eq, lt, ~lt, ltu, ~ltu};
    endfunction

    // Next-state, operand latch, chunk accumulation and flag update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        eq_d      = eq_q;
        ltu_d     = ltu_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        fv_d      = fv_q;
        flags_d   = flags_q;
        a_chunk_s = chunk_of(a_q, cnt_q);
        b_chunk_s = chunk_of(b_q, cnt_q);
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = RUN;
                    a_d     = bus.rs1;
                    b_d     = bus.rs2;
                    eq_d    = 1'b1;
                    ltu_d   = 1'b0;
                    cnt_d   = '0;
                    fv_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // Only the first differing chunk decides the ordering.
                    if (eq_q && (a_chunk_s != b_chunk_s)) begin
                        eq_d  = 1'b0;
                        ltu_d = (a_chunk_s < b_chunk_s);
                    end else begin
                        eq_d  = eq_q;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        fv_d    = 1'b1;
                        flags_d = make_flags(eq_d, ltu_d, a_q[XLEN-1], b_q[XLEN-1]);
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            ltu_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
            flags_q <= 6'b00_0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            ltu_q   <= ltu_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fv_q    <= fv_d;
            flags_q <= flags_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.flags_valid = fv_q;
    assign bus.BEQ         = flags_q[5];
    assign bus.BNE         = flags_q[4];
    assign bus.BLT         = flags_q[3];
    assign bus.BGE         = flags_q[2];
    assign bus.BLTU        = flags_q[1];
    assign bus.BGEU        = flags_q[0];
endmodule
